full_adder_2: RTL and testbench

Single-bit full adder with a registered output stage and input-combination coverage tracking. It is the leaf arithmetic cell used by the adder test structures. The cell drives combinational `sum`/`cout` immediately, plus one-cycle registered copies. It also records which of the eight input combinations have been applied since reset, so a bench can prove exhaustive stimulus.

---
 rtl/full_adder_2_pkg.sv | 22 ++
 rtl/full_adder_2_fa_cell.sv | 20 ++
 rtl/full_adder_2.sv | 80 ++++++++
 tb/tb_full_adder_2.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/full_adder_2_pkg.sv
// Shared types and helpers for the full_adder_2 cell and its coverage tracking.
package full_adder_2_pkg;

  localparam int unsigned NUM_COMBOS = 8;

  typedef logic [2:0]            combo_t;
  typedef logic [NUM_COMBOS-1:0] cov_t;

  // Combination index ordering: {cin, b, a}, so index 3 is a=1, b=1, cin=0.
  function automatic combo_t combo_index(input logic a, input logic b, input logic cin);
    return {cin, b, a};
  endfunction

  // An unknown index leaves the vector untouched, so X/Z inputs never count as a hit.
  function automatic cov_t cov_mark(input cov_t hits, input combo_t idx);
    cov_t marked;
    marked      = hits;
    marked[idx] = 1'b1;
    return marked;
  endfunction

endpackage

// File: rtl/full_adder_2_fa_cell.sv
// Gate-level combinational full adder; the leaf arithmetic of full_adder_2.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic ab;
  logic ac;
  logic bc;

  assign ab   = a & b;
  assign ac   = a & cin;
  assign bc   = b & cin;
  assign sum  = a ^ b ^ cin;
  assign cout = ab | ac | bc;

endmodule

// File: rtl/full_adder_2.sv
// Full adder with registered outputs, input-combination coverage and a saturating
// operation counter. Define FULL_ADDER_2_CHECK_EN to add the sticky arithmetic cross-check `err`.
module full_adder_2
  import full_adder_2_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             cin,
  output logic             sum,
  output logic             cout,
  output logic             sum_q,
  output logic             cout_q,
  output logic [7:0]       cov_hits,
  output logic             cov_done,
  output logic [CNT_W-1:0] op_cnt
`ifdef FULL_ADDER_2_CHECK_EN
  ,
  output logic             err
`endif
);

  logic cell_sum;
  logic cell_cout;
  cov_t cov_next;

  fa_cell u_cell (
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (cell_sum),
    .cout (cell_cout)
  );

  assign sum  = cell_sum;
  assign cout = cell_cout;

  always_comb begin
    cov_next = cov_mark(cov_t'(cov_hits), combo_index(a, b, cin));
  end

  // cov_done looks at the next-state vector so it rises on the edge that sets the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q    <= 1'b0;
      cout_q   <= 1'b0;
      cov_hits <= '0;
      cov_done <= 1'b0;
      op_cnt   <= '0;
    end else begin
      sum_q    <= cell_sum;
      cout_q   <= cell_cout;
      cov_hits <= cov_next;
      cov_done <= &cov_next;
      if (op_cnt != '1) begin
        op_cnt <= op_cnt + CNT_W'(1);
      end
    end
  end

`ifdef FULL_ADDER_2_CHECK_EN
  logic [1:0] arith;

  always_comb begin
    arith = 2'(a) + 2'(b) + 2'(cin);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (arith != {cell_cout, cell_sum}) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_full_adder_2.sv
// Self-checking bench for full_adder_2: arithmetic reference model plus directed vectors.
module tb_full_adder_2;

  logic       clk;
  logic       rst;
  logic       a, b, cin;

  logic       sum, cout, sum_q, cout_q, cov_done;
  logic [7:0] cov_hits;
  logic [7:0] op_cnt;

  logic       s_sum, s_cout, s_sum_q, s_cout_q, s_cov_done;
  logic [7:0] s_cov_hits;
  logic [2:0] s_op_cnt;

`ifdef FULL_ADDER_2_CHECK_EN
  logic       err;
  logic       s_err;
`endif

  full_adder_2 #(.CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sum      (sum),
    .cout     (cout),
    .sum_q    (sum_q),
    .cout_q   (cout_q),
    .cov_hits (cov_hits),
    .cov_done (cov_done),
    .op_cnt   (op_cnt)
`ifdef FULL_ADDER_2_CHECK_EN
    ,
    .err      (err)
`endif
  );

  full_adder_2 #(.CNT_W(3)) dut_small (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sum      (s_sum),
    .cout     (s_cout),
    .sum_q    (s_sum_q),
    .cout_q   (s_cout_q),
    .cov_hits (s_cov_hits),
    .cov_done (s_cov_done),
    .op_cnt   (s_op_cnt)
`ifdef FULL_ADDER_2_CHECK_EN
    ,
    .err      (s_err)
`endif
  );

  int asserts  = 0;
  int failures = 0;
  bit chk_on   = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: arithmetic sum, set of seen combinations, saturating counts.
  bit  seen [8];
  int  m_cnt, m_cnt_small;
  bit  m_sum_q, m_cout_q, m_done;

  always @(posedge clk) begin
    int total;
    logic [7:0] hits;
    total = int'(a) + int'(b) + int'(cin);
    if (rst) begin
      foreach (seen[i]) seen[i] = 1'b0;
      m_cnt = 0; m_cnt_small = 0;
      m_sum_q = 1'b0; m_cout_q = 1'b0; m_done = 1'b0;
    end else begin
      m_sum_q  = bit'(total % 2);
      m_cout_q = bit'(total / 2);
      seen[int'(cin) * 4 + int'(b) * 2 + int'(a)] = 1'b1;
      if (m_cnt < 255) m_cnt++;
      if (m_cnt_small < 7) m_cnt_small++;
      m_done = 1'b1;
      foreach (seen[i]) if (!seen[i]) m_done = 1'b0;
    end
    hits = '0;
    foreach (seen[i]) hits[i] = seen[i];
    #1;
    if (chk_on) begin
      check("sum",        32'(sum),        32'(total % 2));
      check("cout",       32'(cout),       32'(total / 2));
      check("sum_q",      32'(sum_q),      32'(m_sum_q));
      check("cout_q",     32'(cout_q),     32'(m_cout_q));
      check("cov_hits",   32'(cov_hits),   32'(hits));
      check("cov_done",   32'(cov_done),   32'(m_done));
      check("op_cnt",     32'(op_cnt),     32'(m_cnt));
      check("op_cnt_w3",  32'(s_op_cnt),   32'(m_cnt_small));
`ifdef FULL_ADDER_2_CHECK_EN
      check("err",        32'(err),        32'd0);
`endif
    end
  end

  // Called at a falling edge: apply a combination and hold it across one rising edge.
  task automatic step(input int combo);
    {cin, b, a} = 3'(combo);
    @(negedge clk);
  endtask

  // One reset edge with combination 7 applied, which must not be recorded.
  task automatic reset_edge();
    rst = 1'b1;
    {cin, b, a} = 3'b111;
    @(posedge clk);
    #2;
    check("rst_sum_q",    32'(sum_q),    32'd0);
    check("rst_cout_q",   32'(cout_q),   32'd0);
    check("rst_cov_hits", 32'(cov_hits), 32'd0);
    check("rst_cov_done", 32'(cov_done), 32'd0);
    check("rst_op_cnt",   32'(op_cnt),   32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [7:0] sum_tab  = 8'b1001_0110;
  logic [7:0] cout_tab = 8'b1110_1000;

  initial begin
    rst = 1'b1;
    {cin, b, a} = 3'b000;
    @(negedge clk);
    @(negedge clk);
    check("init_op_cnt",   32'(op_cnt),   32'd0);
    check("init_cov_hits", 32'(cov_hits), 32'd0);
    check("comb_in_reset", 32'(sum),      32'd0);
    rst = 1'b0;

    // Exhaustive sweep with literal truth tables.
    for (int i = 0; i < 8; i++) begin
      {cin, b, a} = 3'(i);
      #1;
      check("tab_sum",  32'(sum),  32'(sum_tab[i]));
      check("tab_cout", 32'(cout), 32'(cout_tab[i]));
      @(negedge clk);
    end
    check("sweep_cov_hits", 32'(cov_hits), 32'h0000_00ff);
    check("sweep_cov_done", 32'(cov_done), 32'd1);
    check("sweep_op_cnt",   32'(op_cnt),   32'd8);
    check("sweep_sum_q",    32'(sum_q),    32'd1);
    check("sweep_cout_q",   32'(cout_q),   32'd1);
    check("sweep_op_cnt_w3", 32'(s_op_cnt), 32'd7);

    // Only combination 7, three times.
    reset_edge();
    for (int i = 0; i < 3; i++) step(7);
    check("c7_cov_hits", 32'(cov_hits), 32'h0000_0080);
    check("c7_cov_done", 32'(cov_done), 32'd0);
    check("c7_op_cnt",   32'(op_cnt),   32'd3);
    check("c7_sum_q",    32'(sum_q),    32'd1);
    check("c7_cout_q",   32'(cout_q),   32'd1);

    // Mid-sequence reset restarts coverage.
    reset_edge();
    for (int i = 0; i < 5; i++) step(i);
    check("pre_cov_hits", 32'(cov_hits), 32'h0000_001f);
    reset_edge();
    step(5);
    step(6);
    check("post_cov_hits", 32'(cov_hits), 32'h0000_0060);
    check("post_op_cnt",   32'(op_cnt),   32'd2);
    check("post_sum_q",    32'(sum_q),    32'd0);
    check("post_cout_q",   32'(cout_q),   32'd1);

    // Saturation of the narrow counter.
    reset_edge();
    for (int i = 0; i < 10; i++) step(i % 8);
    check("sat_op_cnt_w3", 32'(s_op_cnt), 32'd7);
    check("sat_op_cnt",    32'(op_cnt),   32'd10);
    check("sat_cov_done",  32'(cov_done), 32'd1);

`ifdef FULL_ADDER_2_CHECK_EN
    check("chk_err_clean", 32'(err), 32'd0);
    chk_on = 1'b0;
    {cin, b, a} = 3'b000;
    force dut.u_cell.sum = 1'b1;
    @(posedge clk);
    #2;
    check("chk_err_set", 32'(err), 32'd1);
    @(negedge clk);
    release dut.u_cell.sum;
    step(3);
    check("chk_err_sticky", 32'(err), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #2;
    check("chk_err_rst", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;
    step(1);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
